traffic_phase_sequencer: RTL and testbench
==========================================

TRAFFIC_PHASE_SEQUENCER -- requirements
Module: traffic_phase_sequencer

Interface
REQ-001 Parameter NUM_DIR, default 4: number of approach directions, legal range 2..8.
REQ-002 Parameter CLK_FREQ, default 100_000_000: clock cycles per second.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port green_duration, input, 8: green time in seconds.
REQ-006 Port yellow_duration, input, 8: yellow time in seconds.
REQ-007 Port red_holding, input, 8: all-red clearance time in seconds.
REQ-008 Port demand, input, NUM_DIR: per-direction vehicle or pedestrian request; a one-cycle pulse is sufficient.
REQ-009 Port preempt / preempt_dir, input, 1 / DIR_W: emergency request and target direction; present only with TLC_PREEMPT_EN.
REQ-010 Port red / yellow / green, output, NUM_DIR each: lamp vectors, bit i = direction i.
REQ-011 Port active_direction, output, DIR_W = $clog2(NUM_DIR): direction that owns the current or most recent green.
REQ-012 Port countdown_sec, output, 8: seconds remaining in the current phase.
REQ-013 Port phase_done, output, 1: one-cycle pulse on every phase change.

Function
REQ-014 The FSM SHALL have states GREEN, YELLOW and ALL_RED, plus PREEMPT when TLC_PREEMPT_EN is defined.
REQ-015 On entry to each phase, countdown_sec SHALL load the phase duration, with a value of 0 treated as 1.
- Durations are sampled only at phase entry; mid-phase input changes do not apply until the next phase.
REQ-016 A 1 Hz tick prescaler SHALL restart at every phase entry, so the first second of each phase is a full CLK_FREQ cycles.
REQ-017 On each tick, countdown_sec SHALL decrement if it is greater than 1; otherwise the phase expires on that tick.
REQ-018 Each demand bit SHALL set a sticky pending bit.
- The pending bit of direction active_direction clears on entry to GREEN.
- Demand for the direction that is currently green is ignored.
REQ-019 On GREEN expiry, if any other direction has a pending bit set, the FSM SHALL go to YELLOW.
- Otherwise it rests in green: GREEN re-enters with green_duration reloaded and phase_done pulsed.
REQ-020 On YELLOW expiry, the FSM SHALL go to ALL_RED.
REQ-021 On ALL_RED expiry, active_direction SHALL become the first pending direction searched round-robin from active_direction+1, wrapping at NUM_DIR-1 to 0.
- If no direction is pending, active_direction becomes active_direction+1 (mod NUM_DIR).
- The FSM then enters GREEN.
REQ-022 Lamp outputs SHALL be registered and exactly one-hot per direction: red, yellow or green.
- Only direction active_direction may show non-red.
- In ALL_RED, every direction is red.
REQ-023 A demand pulse and the expiry tick arriving in the same cycle SHALL both take effect: the pulse counts as pending for that cycle's decision.
REQ-024 The prescaler SHALL be ceil(log2(CLK_FREQ)) bits wide and wrap at CLK_FREQ-1.
- countdown_sec arithmetic is 8-bit unsigned and never underflows.

Reset
REQ-025 While rst is high, the block SHALL hold:
- state = ALL_RED, active_direction = NUM_DIR-1, countdown_sec = 1;
- prescaler = 0, pending = 0, red = all ones, yellow = green = 0, phase_done = 0.
REQ-026 After rst deasserts, the first tick SHALL enter GREEN on direction 0.
REQ-027 A reset asserted mid-phase SHALL abandon the phase immediately, with no yellow.

Configuration
REQ-028 With TLC_PREEMPT_EN defined, preempt high in GREEN for a direction other than preempt_dir SHALL force YELLOW, then ALL_RED, then PREEMPT.
- PREEMPT shows green on preempt_dir and holds while preempt stays high; countdown_sec = 0.
- When preempt is high in GREEN on preempt_dir, the FSM enters PREEMPT directly.
- When preempt falls, PREEMPT goes to YELLOW and then resumes normal sequencing.
- Pending bits are preserved across preemption.
REQ-029 Without TLC_PREEMPT_EN, the preempt and preempt_dir ports and the PREEMPT state SHALL be absent, and behaviour SHALL be exactly REQ-014..027.

Structure
REQ-030 The phase encoding enum and the default-duration constants SHALL live in the shared package tlc_pkg.
REQ-031 The prescaler SHALL be the sub-module tlc_tick_gen, with inputs clk, rst, restart and output tick.
- It is parameterised by CLK_FREQ.

Verification (CLK_FREQ=10, NUM_DIR=4, durations G=3, Y=2, R=1)
REQ-032 Release reset with no demand -> dir 0 green at tick 1, countdown 3,2,1; it then rests green, reloading 3 with a phase_done pulse every 30 cycles.
REQ-033 Pulse demand[2] during dir 0 green -> yellow for 20 cycles, all-red for 10 cycles, then dir 2 green; dir 1 is skipped.
REQ-034 Pulse demand[1] and demand[3] together while dir 2 is green -> service order 3 then 1 (round-robin wrap).
REQ-035 Change green_duration from 3 to 5 mid-green -> the current green still expires at 3 s; the next green loads 5.
REQ-036 Assert rst during yellow -> all outputs return to their reset values on the same edge, asynchronously.
REQ-037 With TLC_PREEMPT_EN: preempt=1, preempt_dir=3 during dir 0 green -> Y(2 s), R(1 s), dir 3 green held while preempt is high; on release -> Y then ALL_RED, with pending demand served next.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared phase encoding, default phase durations and duration helpers for the
// traffic phase sequencer.
package tlc_pkg;

    typedef enum logic [1:0] {
        PH_GREEN   = 2'd0,
        PH_YELLOW  = 2'd1,
        PH_ALL_RED = 2'd2,
        PH_PREEMPT = 2'd3
    } phase_e;

    localparam logic [1:0] ST_GREEN   = PH_GREEN;
    localparam logic [1:0] ST_YELLOW  = PH_YELLOW;
    localparam logic [1:0] ST_ALL_RED = PH_ALL_RED;
    localparam logic [1:0] ST_PREEMPT = PH_PREEMPT;

    localparam logic [7:0] DEFAULT_GREEN_SEC  = 8'd30;
    localparam logic [7:0] DEFAULT_YELLOW_SEC = 8'd4;
    localparam logic [7:0] DEFAULT_RED_SEC    = 8'd2;

    // A zero duration would never expire cleanly, so it is stretched to 1 s.
    function automatic logic [7:0] phase_load(input logic [7:0] dur);
        return (dur == 8'd0) ? 8'd1 : dur;
    endfunction

endpackage

// File: rtl/tlc_tick_gen.sv
// One-second tick prescaler; restart realigns the second to the current cycle
// so a freshly entered phase always gets a full first second.
module tlc_tick_gen #(
    parameter int CLK_FREQ = 100_000_000,
    localparam int CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_FREQ - 1);

    logic [CNT_W-1:0] count_reg;

    assign tick = (count_reg == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (restart || tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Round-robin traffic light phase sequencer with sticky per-direction demand.
// Define TLC_PREEMPT_EN to add the emergency preemption port pair and state.
module traffic_phase_sequencer
    import tlc_pkg::*;
#(
    parameter int NUM_DIR  = 4,
    parameter int CLK_FREQ = 100_000_000,
    localparam int DIR_W   = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         green_duration,
    input  logic [7:0]         yellow_duration,
    input  logic [7:0]         red_holding,
    input  logic [NUM_DIR-1:0] demand,
`ifdef TLC_PREEMPT_EN
    input  logic               preempt,
    input  logic [DIR_W-1:0]   preempt_dir,
`endif
    output logic [NUM_DIR-1:0] red,
    output logic [NUM_DIR-1:0] yellow,
    output logic [NUM_DIR-1:0] green,
    output logic [DIR_W-1:0]   active_direction,
    output logic [7:0]         countdown_sec,
    output logic               phase_done
);

    logic [1:0]         state_reg, state_next;
    logic [DIR_W-1:0]   active_reg, active_next;
    logic [7:0]         countdown_reg, countdown_next;
    logic [NUM_DIR-1:0] pending_reg, pending_next;
    logic [NUM_DIR-1:0] red_reg, yellow_reg, green_reg;
    logic [NUM_DIR-1:0] red_next, yellow_next, green_next;
    logic               phase_done_reg;
    logic [NUM_DIR-1:0] active_mask, next_mask, rr_mask, pend_eff;
    logic [DIR_W-1:0]   rr_dir;
    logic               tick, enter;

    function automatic logic [DIR_W-1:0] dir_add(input logic [DIR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_DIR) s = s - NUM_DIR;
        return DIR_W'(s);
    endfunction

    tlc_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (enter),
        .tick    (tick)
    );

    // Effective pending includes this cycle's demand, so a pulse coinciding
    // with an expiry tick still steers that tick's decision.
    always_comb begin
        active_mask = '0;
        active_mask[active_reg] = 1'b1;
        pend_eff = pending_reg | demand;
        if (state_reg == ST_GREEN || state_reg == ST_PREEMPT) begin
            pend_eff = pend_eff & ~active_mask;
        end
        rr_dir = dir_add(active_reg, 1);
        for (int k = NUM_DIR; k >= 1; k--) begin
            if (pend_eff[dir_add(active_reg, k)]) rr_dir = dir_add(active_reg, k);
        end
        rr_mask = '0;
        rr_mask[rr_dir] = 1'b1;
    end

    always_comb begin
        state_next     = state_reg;
        active_next    = active_reg;
        countdown_next = countdown_reg;
        pending_next   = pend_eff;
        enter          = 1'b0;
        case (state_reg)
            ST_GREEN: begin
`ifdef TLC_PREEMPT_EN
                if (preempt) begin
                    enter = 1'b1;
                    if (preempt_dir == active_reg) begin
                        state_next     = ST_PREEMPT;
                        countdown_next = 8'd0;
                    end else begin
                        state_next     = ST_YELLOW;
                        countdown_next = phase_load(yellow_duration);
                    end
                end else
`endif
                if (tick) begin
                    if (countdown_reg > 8'd1) begin
                        countdown_next = countdown_reg - 8'd1;
                    end else if (|pend_eff) begin
                        enter          = 1'b1;
                        state_next     = ST_YELLOW;
                        countdown_next = phase_load(yellow_duration);
                    end else begin
                        enter          = 1'b1;
                        countdown_next = phase_load(green_duration);
                    end
                end
            end
            ST_YELLOW: begin
                if (tick) begin
                    if (countdown_reg > 8'd1) begin
                        countdown_next = countdown_reg - 8'd1;
                    end else begin
                        enter          = 1'b1;
                        state_next     = ST_ALL_RED;
                        countdown_next = phase_load(red_holding);
                    end
                end
            end
            ST_ALL_RED: begin
                if (tick) begin
                    if (countdown_reg > 8'd1) begin
                        countdown_next = countdown_reg - 8'd1;
                    end else begin
                        enter = 1'b1;
`ifdef TLC_PREEMPT_EN
                        if (preempt) begin
                            state_next     = ST_PREEMPT;
                            active_next    = preempt_dir;
                            countdown_next = 8'd0;
                        end else
`endif
                        begin
                            state_next     = ST_GREEN;
                            active_next    = rr_dir;
                            countdown_next = phase_load(green_duration);
                            pending_next   = pend_eff & ~rr_mask;
                        end
                    end
                end
            end
`ifdef TLC_PREEMPT_EN
            ST_PREEMPT: begin
                if (!preempt) begin
                    enter          = 1'b1;
                    state_next     = ST_YELLOW;
                    countdown_next = phase_load(yellow_duration);
                end
            end
`endif
            default: begin
                enter          = 1'b1;
                state_next     = ST_ALL_RED;
                countdown_next = 8'd1;
            end
        endcase
    end

    // Lamps are derived from the next state so they register alongside it.
    always_comb begin
        next_mask = '0;
        next_mask[active_next] = 1'b1;
        red_next    = ~next_mask;
        yellow_next = '0;
        green_next  = '0;
        case (state_next)
            ST_GREEN, ST_PREEMPT: green_next  = next_mask;
            ST_YELLOW:            yellow_next = next_mask;
            default:              red_next    = '1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_ALL_RED;
            active_reg     <= DIR_W'(NUM_DIR - 1);
            countdown_reg  <= 8'd1;
            pending_reg    <= '0;
            red_reg        <= '1;
            yellow_reg     <= '0;
            green_reg      <= '0;
            phase_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            active_reg     <= active_next;
            countdown_reg  <= countdown_next;
            pending_reg    <= pending_next;
            red_reg        <= red_next;
            yellow_reg     <= yellow_next;
            green_reg      <= green_next;
            phase_done_reg <= enter;
        end
    end

    assign red              = red_reg;
    assign yellow           = yellow_reg;
    assign green            = green_reg;
    assign active_direction = active_reg;
    assign countdown_sec    = countdown_reg;
    assign phase_done       = phase_done_reg;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer at CLK_FREQ=10, NUM_DIR=4, G/Y/R = 3/2/1 s.
module tb_traffic_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] green_duration, yellow_duration, red_holding;
    logic [3:0] demand;
    logic [3:0] red, yellow, green;
    logic [1:0] active_direction;
    logic [7:0] countdown_sec;
    logic       phase_done;
`ifdef TLC_PREEMPT_EN
    logic       preempt;
    logic [1:0] preempt_dir;
`endif

    int total = 0;
    int bad   = 0;

    traffic_phase_sequencer #(.NUM_DIR(4), .CLK_FREQ(10)) dut (
        .clk              (clk),
        .rst              (rst),
        .green_duration   (green_duration),
        .yellow_duration  (yellow_duration),
        .red_holding      (red_holding),
        .demand           (demand),
`ifdef TLC_PREEMPT_EN
        .preempt          (preempt),
        .preempt_dir      (preempt_dir),
`endif
        .red              (red),
        .yellow           (yellow),
        .green            (green),
        .active_direction (active_direction),
        .countdown_sec    (countdown_sec),
        .phase_done       (phase_done)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            $display("check %s obs=%0h exp=%0h ok", tag, obs, exp);
        end else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lamps(input string tag, input logic [3:0] r, input logic [3:0] y,
                             input logic [3:0] g, input logic [1:0] dir, input logic [7:0] cnt);
        chk({tag, ".red"}, 32'(red), 32'(r));
        chk({tag, ".yellow"}, 32'(yellow), 32'(y));
        chk({tag, ".green"}, 32'(green), 32'(g));
        chk({tag, ".dir"}, 32'(active_direction), 32'(dir));
        chk({tag, ".cnt"}, 32'(countdown_sec), 32'(cnt));
    endtask

    initial begin
        rst = 1'b1;
        demand = 4'b0000;
        green_duration = 8'd3;
        yellow_duration = 8'd2;
        red_holding = 8'd1;
`ifdef TLC_PREEMPT_EN
        preempt = 1'b0;
        preempt_dir = 2'd0;
`endif
        cyc(3);
        chk_lamps("reset", 4'b1111, 4'b0000, 4'b0000, 2'd3, 8'd1);
        chk("reset.pd", 32'(phase_done), 32'd0);
        rst = 1'b0;

        cyc(9);
        chk_lamps("pre_tick", 4'b1111, 4'b0000, 4'b0000, 2'd3, 8'd1);
        cyc(1);
        chk_lamps("first_green", 4'b1110, 4'b0000, 4'b0001, 2'd0, 8'd3);
        chk("first_green.pd", 32'(phase_done), 32'd1);
        cyc(1);
        chk("pd_one_cycle", 32'(phase_done), 32'd0);
        cyc(9);
        chk("cnt2", 32'(countdown_sec), 32'd2);
        cyc(10);
        chk("cnt1", 32'(countdown_sec), 32'd1);
        cyc(9);
        chk("cnt1_late", 32'(countdown_sec), 32'd1);
        cyc(1);
        chk_lamps("rest_green", 4'b1110, 4'b0000, 4'b0001, 2'd0, 8'd3);
        chk("rest_green.pd", 32'(phase_done), 32'd1);

        // demand[0] is ignored because direction 0 is green; demand[2] sticks
        demand = 4'b0101;
        cyc(1);
        demand = 4'b0000;
        cyc(29);
        chk_lamps("yellow0", 4'b1110, 4'b0001, 4'b0000, 2'd0, 8'd2);
        chk("yellow0.pd", 32'(phase_done), 32'd1);
        cyc(20);
        chk_lamps("allred0", 4'b1111, 4'b0000, 4'b0000, 2'd0, 8'd1);
        cyc(10);
        chk_lamps("green2", 4'b1011, 4'b0000, 4'b0100, 2'd2, 8'd3);

        demand = 4'b1010;
        green_duration = 8'd5;
        cyc(1);
        demand = 4'b0000;
        cyc(29);
        chk_lamps("yellow2", 4'b1011, 4'b0100, 4'b0000, 2'd2, 8'd2);
        cyc(30);
        chk_lamps("green3", 4'b0111, 4'b0000, 4'b1000, 2'd3, 8'd5);
        cyc(49);
        chk_lamps("green3_end", 4'b0111, 4'b0000, 4'b1000, 2'd3, 8'd1);
        cyc(1);
        chk_lamps("yellow3", 4'b0111, 4'b1000, 4'b0000, 2'd3, 8'd2);
        cyc(30);
        chk_lamps("green1", 4'b1101, 4'b0000, 4'b0010, 2'd1, 8'd5);

        // demand arriving on the expiry edge must still trigger a yellow
        cyc(49);
        demand = 4'b0001;
        cyc(1);
        demand = 4'b0000;
        chk_lamps("same_cycle", 4'b1101, 4'b0010, 4'b0000, 2'd1, 8'd2);
        cyc(30);
        chk_lamps("green0", 4'b1110, 4'b0000, 4'b0001, 2'd0, 8'd5);

        demand = 4'b0010;
        cyc(1);
        demand = 4'b0000;
        cyc(49);
        chk_lamps("yellow_pre_rst", 4'b1110, 4'b0001, 4'b0000, 2'd0, 8'd2);
        cyc(5);
        #2;
        rst = 1'b1;
        #1;
        chk_lamps("async_rst", 4'b1111, 4'b0000, 4'b0000, 2'd3, 8'd1);
        chk("async_rst.pd", 32'(phase_done), 32'd0);
        cyc(2);
        chk_lamps("rst_held", 4'b1111, 4'b0000, 4'b0000, 2'd3, 8'd1);
        rst = 1'b0;
        cyc(10);
        chk_lamps("green_after_rst", 4'b1110, 4'b0000, 4'b0001, 2'd0, 8'd5);
        cyc(50);
        chk_lamps("rest_after_rst", 4'b1110, 4'b0000, 4'b0001, 2'd0, 8'd5);
        chk("rest_after_rst.pd", 32'(phase_done), 32'd1);

`ifdef TLC_PREEMPT_EN
        preempt_dir = 2'd3;
        preempt = 1'b1;
        cyc(1);
        chk_lamps("pre_yellow", 4'b1110, 4'b0001, 4'b0000, 2'd0, 8'd2);
        cyc(20);
        chk_lamps("pre_allred", 4'b1111, 4'b0000, 4'b0000, 2'd0, 8'd1);
        cyc(10);
        chk_lamps("preempt3", 4'b0111, 4'b0000, 4'b1000, 2'd3, 8'd0);
        cyc(15);
        chk_lamps("preempt_hold", 4'b0111, 4'b0000, 4'b1000, 2'd3, 8'd0);
        preempt = 1'b0;
        cyc(1);
        chk_lamps("post_yellow", 4'b0111, 4'b1000, 4'b0000, 2'd3, 8'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
